alu_digit_serial: RTL

Parametrised multi-cycle ALU that processes WIDTH-bit operands in DIGIT-bit slices, LSB slice first, carrying between slices in a register. It is the successor to the single-bit ripple ALU cell and serves as the RV32EC execute unit when area matters more than latency. It adds AND, SLT and SLTU to the existing ADD/SUB/OR/XOR set. Operands enter through a valid/ready handshake and results leave through one.

---
 rtl/alu_digit_serial.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_digit_serial.sv
// alu_digit_serial: multi-cycle ALU that walks WIDTH-bit operands in DIGIT-bit
// slices, least significant slice first, with a registered carry between slices.
// Operands arrive through a valid/ready handshake and the result leaves through one.
// SLT/SLTU finish on the last slice by replacing the accumulated difference with
// the comparison outcome.
module alu_digit_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_kill,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int LSBW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;

    // Operations that run the adder as a + ~b + 1.
    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;

    logic [LSBW-1:0]  w_lsb;
    logic [DIGIT-1:0] w_a_sl;
    logic [DIGIT-1:0] w_b_sl;
    logic [DIGIT-1:0] w_b_eff;
    logic [DIGIT:0]   w_sum;
    logic [DIGIT-1:0] w_slice;
    logic             w_cout;
    logic             w_ovf;
    logic             w_lt_signed;
    logic             w_last;
    logic             w_in_ready;
    logic             w_out_valid;

    assign w_lsb  = LSBW'(r_idx) * LSBW'(DIGIT);
    assign w_a_sl = r_a[w_lsb +: DIGIT];
    assign w_b_sl = r_b[w_lsb +: DIGIT];
    assign w_last = (r_idx == IDXW'(NDIG - 1));

    // Slice datapath: adder for arithmetic ops, bitwise unit for logic ops.
    always_comb begin
        w_b_eff = w_b_sl;
        w_sum   = {(DIGIT + 1){1'b0}};
        w_slice = {DIGIT{1'b0}};
        w_cout  = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_sum   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{DIGIT{1'b0}}, r_carry};
                w_slice = w_sum[DIGIT-1:0];
                w_cout  = w_sum[DIGIT];
            end
            OP_SUB, OP_SLT, OP_SLTU: begin
                w_b_eff = ~w_b_sl;
                w_sum   = {1'b0, w_a_sl} + {1'b0, ~w_b_sl} + {{DIGIT{1'b0}}, r_carry};
                w_slice = w_sum[DIGIT-1:0];
                w_cout  = w_sum[DIGIT];
            end
            OP_XOR:  w_slice = w_a_sl ^ w_b_sl;
            OP_OR:   w_slice = w_a_sl | w_b_sl;
            OP_AND:  w_slice = w_a_sl & w_b_sl;
            default: w_slice = {DIGIT{1'b0}};
        endcase
    end

    // Signed overflow of the top slice: operands agree in sign, sum does not.
    assign w_ovf       = (w_a_sl[DIGIT-1] == w_b_eff[DIGIT-1]) && (w_slice[DIGIT-1] != w_a_sl[DIGIT-1]);
    assign w_lt_signed = w_slice[DIGIT-1] ^ w_ovf;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; kill wins over hand-off in DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (i_kill) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DONE: begin
                if (i_kill || i_out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: w_in_ready  = 1'b0;
        endcase
    end

    // Operand capture on accept, then one slice per RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_op     <= 3'b000;
            r_idx    <= {IDXW{1'b0}};
            r_carry  <= 1'b0;
            r_result <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_op    <= i_op;
                        r_idx   <= {IDXW{1'b0}};
                        r_carry <= is_sub(i_op);
                    end
                end
                S_RUN: begin
                    if (!i_kill) begin
                        r_carry <= w_cout;
                        if (w_last) begin
                            r_idx <= {IDXW{1'b0}};
                            case (r_op)
                                OP_SLT:  r_result <= {{(WIDTH - 1){1'b0}}, w_lt_signed};
                                OP_SLTU: r_result <= {{(WIDTH - 1){1'b0}}, ~w_cout};
                                default: r_result[w_lsb +: DIGIT] <= w_slice;
                            endcase
                        end else begin
                            r_idx <= r_idx + IDXW'(1);
                            r_result[w_lsb +: DIGIT] <= w_slice;
                        end
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_result    = r_result;
    assign o_carry     = r_carry;
    assign o_zero      = (r_result == {WIDTH{1'b0}});

endmodule
